debounce_bank: RTL and testbench



---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_ch.sv | 73 +++++++
 rtl/debounce_bank.sv | 42 ++++
 tb/tb_debounce_bank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared width helpers and 100 MHz board defaults for the debounce bank
package debounce_pkg;

    localparam int DEF_DELAY       = 1_000_000;
    localparam int DEF_HOLD_CYCLES = 100_000_000;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int cnt_width(input int delay);
        return clog2(delay + 1);
    endfunction

    function automatic int hold_width(input int hold_cycles);
        return clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel - synchroniser, stability counter, debounced level, press/release strobes, optional long-press (DEBOUNCE_HOLD_EN)
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int DELAY       = DEF_DELAY,
    parameter int SYNC_STAGES = 2
`ifdef DEBOUNCE_HOLD_EN
    ,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
`endif
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn_in,
    output logic o_btn_db,
    output logic o_rise,
    output logic o_fall,
    output logic o_hold
);

    localparam int CNT_W = cnt_width(DELAY);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   flip;

    assign s    = sync[SYNC_STAGES-1];
    assign flip = (s != o_btn_db) && (cnt == LAST);

    // shift the asynchronous pin through the synchroniser chain
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) sync <= '0;
        else         sync <= {sync[SYNC_STAGES-2:0], i_btn_in};
    end

    // count consecutive disagreeing cycles; commit the new level and strobe on the DELAY-th
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt      <= '0;
            o_btn_db <= 1'b0;
            o_rise   <= 1'b0;
            o_fall   <= 1'b0;
        end else begin
            cnt      <= (s == o_btn_db || flip) ? '0 : cnt + 1'b1;
            o_btn_db <= flip ? s : o_btn_db;
            o_rise   <= flip & s;
            o_fall   <= flip & ~s;
        end
    end

`ifdef DEBOUNCE_HOLD_EN
    localparam int HOLD_W = hold_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HMAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hc;

    // time the high level from the press cycle; saturation leaves one pulse per press
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hc     <= '0;
            o_hold <= 1'b0;
        end else begin
            hc     <= !o_btn_db ? '0 : (hc == HMAX) ? hc : hc + 1'b1;
            o_hold <= o_btn_db && (hc == HMAX - 1'b1);
        end
    end
`else
    assign o_hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounced buttons with press/release strobes; long-press under DEBOUNCE_HOLD_EN
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DELAY       = DEF_DELAY,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [N_CH-1:0] i_btn_in,
    output logic [N_CH-1:0] o_btn_db,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_hold
);

    if (N_CH < 1 || N_CH > 32 || DELAY < 1 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES <= DELAY) begin : g_bad_params
        $error("debounce_bank: illegal parameter combination");
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        debounce_ch #(
            .DELAY       (DELAY),
            .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCE_HOLD_EN
            ,
            .HOLD_CYCLES (HOLD_CYCLES)
`endif
        ) u_ch (
            .i_clk    (i_clk),
            .i_rstn   (i_rstn),
            .i_btn_in (i_btn_in[k]),
            .o_btn_db (o_btn_db[k]),
            .o_rise   (o_rise[k]),
            .o_fall   (o_fall[k]),
            .o_hold   (o_hold[k])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: scoreboard bench - expected strobe events queued with stimulus, matched as the DUT pulses
module tb_debounce_bank;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  db;
        logic [3:0]  rise;
        logic [3:0]  fall;
        logic [3:0]  hold;
    } ev_t;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic [3:0] i_btn_in = 4'h0;
    logic [3:0] o_btn_db, o_rise, o_fall, o_hold;

    ev_t         q[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned c;

    debounce_bank #(
        .N_CH        (4),
        .DELAY       (8),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (32)
    ) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_btn_in (i_btn_in),
        .o_btn_db (o_btn_db),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_hold   (o_hold)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int unsigned t, input logic [3:0] db, input logic [3:0] r, input logic [3:0] f, input logic [3:0] h);
        ev_t e;
        e.cyc  = t;
        e.db   = db;
        e.rise = r;
        e.fall = f;
        e.hold = h;
        q.push_back(e);
    endtask

    always @(negedge i_clk) begin
        ev_t e;
        if ((o_rise | o_fall | o_hold) != 4'h0) begin
            if (q.size() == 0) begin
                check("spurious_pulse", {20'h0, o_rise, o_fall, o_hold}, 32'h0);
            end else begin
                e = q.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_db", {28'h0, o_btn_db}, {28'h0, e.db});
                check("ev_rise", {28'h0, o_rise}, {28'h0, e.rise});
                check("ev_fall", {28'h0, o_fall}, {28'h0, e.fall});
                check("ev_hold", {28'h0, o_hold}, {28'h0, e.hold});
            end
        end
    end

    initial begin
        // reset with all pins high
        i_btn_in = 4'hF;
        repeat (3) @(negedge i_clk);
        check("rst_db", {28'h0, o_btn_db}, 32'h0);
        check("rst_rise", {28'h0, o_rise}, 32'h0);
        check("rst_fall", {28'h0, o_fall}, 32'h0);
        check("rst_hold", {28'h0, o_hold}, 32'h0);
        i_rstn = 1'b1;
        push(cyc + 10, 4'hF, 4'hF, 4'h0, 4'h0);
        repeat (9) @(negedge i_clk);
        check("rst_db_early", {28'h0, o_btn_db}, 32'h0);
        repeat (3) @(negedge i_clk);
        check("rst_db_after", {28'h0, o_btn_db}, 32'hF);
        i_btn_in = 4'h0;
        push(cyc + 10, 4'h0, 4'h0, 4'hF, 4'h0);
        repeat (14) @(negedge i_clk);
        check("release_all_db", {28'h0, o_btn_db}, 32'h0);

        // glitch filter on ch0: 7-cycle highs never pass
        for (int i = 0; i < 20; i++) begin
            i_btn_in[0] = 1'b1;
            repeat (7) @(negedge i_clk);
            i_btn_in[0] = 1'b0;
            repeat ($urandom_range(7, 1)) @(negedge i_clk);
        end
        repeat (12) @(negedge i_clk);
        check("glitch_db", {28'h0, o_btn_db}, 32'h0);

        // clean press and release on ch2
        i_btn_in[2] = 1'b1;
        push(cyc + 10, 4'b0100, 4'b0100, 4'h0, 4'h0);
        repeat (20) @(negedge i_clk);
        check("ch2_db_high", {28'h0, o_btn_db}, 32'h4);
        i_btn_in[2] = 1'b0;
        push(cyc + 10, 4'h0, 4'h0, 4'b0100, 4'h0);
        repeat (14) @(negedge i_clk);
        check("ch2_db_low", {28'h0, o_btn_db}, 32'h0);

        // mismatch restart on ch1: 6 high, 1 low, 8 high
        i_btn_in[1] = 1'b1;
        repeat (6) @(negedge i_clk);
        i_btn_in[1] = 1'b0;
        @(negedge i_clk);
        i_btn_in[1] = 1'b1;
        push(cyc + 10, 4'b0010, 4'b0010, 4'h0, 4'h0);
        repeat (8) @(negedge i_clk);
        check("ch1_db_pre", {28'h0, o_btn_db}, 32'h0);
        i_btn_in[1] = 1'b0;
        push(cyc + 10, 4'h0, 4'h0, 4'b0010, 4'h0);
        repeat (14) @(negedge i_clk);

        // simultaneous press on ch0 and ch3, held long enough for a long-press
        i_btn_in = 4'b1001;
        c = cyc;
        push(c + 10, 4'b1001, 4'b1001, 4'h0, 4'h0);
`ifdef DEBOUNCE_HOLD_EN
        push(c + 42, 4'b1001, 4'h0, 4'h0, 4'b1001);
`endif
        repeat (60) @(negedge i_clk);
        check("sim_db", {28'h0, o_btn_db}, 32'h9);
        i_btn_in = 4'h0;
        push(cyc + 10, 4'h0, 4'h0, 4'b1001, 4'h0);
        repeat (14) @(negedge i_clk);

        // reset mid-count on ch1, pin held through reset
        i_btn_in[1] = 1'b1;
        repeat (5) @(negedge i_clk);
        i_rstn = 1'b0;
        #1;
        check("midrst_db", {28'h0, o_btn_db}, 32'h0);
        repeat (4) @(negedge i_clk);
        i_rstn = 1'b1;
        push(cyc + 10, 4'b0010, 4'b0010, 4'h0, 4'h0);
        repeat (9) @(negedge i_clk);
        check("midrst_db_early", {28'h0, o_btn_db}, 32'h0);
        repeat (3) @(negedge i_clk);
        check("midrst_db_after", {28'h0, o_btn_db}, 32'h2);
        i_btn_in = 4'h0;
        push(cyc + 10, 4'h0, 4'h0, 4'b0010, 4'h0);
        repeat (14) @(negedge i_clk);

        check("queue_drained", q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
